// File: rtl/fp32_to_int_conv_if.sv
// Stream bundle for the FP32 -> fixed-point converter: the input
// valid/ready/data channel plus the output valid/ready/data/flags channel.
// The slave modport is the converter's view, the master modport is the
// view of whatever feeds it and drains it.
interface fp32_to_int_conv_if #(
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_ovf;
    logic             out_nan;
    logic             out_inexact;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, out_nan, out_inexact
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf, out_nan, out_inexact
    );
endinterface

// File: rtl/fp32_to_int_conv.sv
// Two-stage streaming converter from IEEE-754 single precision to a signed
// OUT_W-bit fixed-point word with FRAC_BITS fractional bits. Stage 1
// classifies the operand and computes the shift amount; stage 2 shifts,
// rounds, saturates and negates. Both stages hold under backpressure so at
// most two items are buffered and throughput is one word per cycle.
// Optional feature macro: FP32_TO_INT_RNE_EN selects round-to-nearest-even;
// when it is undefined the magnitude is truncated toward zero.
module fp32_to_int_conv #(
    parameter int OUT_W     = 32,
    parameter int FRAC_BITS = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    fp32_to_int_conv_if.slave    bus
);

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_DENORM,
        CLS_NORMAL,
        CLS_INF,
        CLS_NAN
    } cls_t;

    localparam logic [63:0]      POS_MAX = (64'd1 << (OUT_W - 1)) - 64'd1;
    localparam logic [63:0]      NEG_MAX = 64'd1 << (OUT_W - 1);
    localparam logic [OUT_W-1:0] POS_SAT = POS_MAX[OUT_W-1:0];
    localparam logic [OUT_W-1:0] NEG_SAT = NEG_MAX[OUT_W-1:0];

    logic              v1;
    logic              v2;
    cls_t              cls1;
    logic              s1;
    logic [23:0]       m1;
    logic signed [9:0] sh1;

    logic              adv1;
    logic              in_ready;

    logic [7:0]        exp_in;
    logic [22:0]       frac_in;
    cls_t              cls_in;
    logic [9:0]        sh_in;

    logic [63:0]       mag;
    logic [63:0]       mag_r;
    logic              guard;
    logic              sticky;
    logic [9:0]        nsh;
    logic [48:0]       ext;

    logic [OUT_W-1:0]  res_data;
    logic              res_ovf;
    logic              res_nan;
    logic              res_inexact;

    logic [OUT_W-1:0]  data2;
    logic              ovf2;
    logic              nan2;
    logic              inexact2;

    // Stage 2 can take a new item when it is empty or being drained; stage 1
    // can take one when it is empty or moving into stage 2.
    assign adv1        = !v2 || bus.out_ready;
    assign in_ready    = !v1 || adv1;
    assign bus.in_ready = in_ready;

    assign exp_in  = bus.in_data[30:23];
    assign frac_in = bus.in_data[22:0];
    assign sh_in   = 10'({2'b00, exp_in}) - 10'd150 + 10'(FRAC_BITS);

    // Classify the incoming operand by its exponent and fraction fields.
    always_comb begin
        cls_in = CLS_NORMAL;
        if (exp_in == 8'hFF) begin
            cls_in = (frac_in != 23'd0) ? CLS_NAN : CLS_INF;
        end else if (exp_in == 8'h00) begin
            cls_in = (frac_in != 23'd0) ? CLS_DENORM : CLS_ZERO;
        end
    end

    // Stage 1 register: class, sign, significand with hidden bit, shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            cls1 <= CLS_ZERO;
            s1   <= 1'b0;
            m1   <= 24'd0;
            sh1  <= 10'sd0;
        end else if (in_ready) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                cls1 <= cls_in;
                s1   <= bus.in_data[31];
                m1   <= {1'b1, frac_in};
                sh1  <= $signed(sh_in);
            end
        end
    end

    // Align the significand; right shifts keep guard and sticky, and a
    // shift of 25 or more leaves only a sticky contribution. Left shifts of
    // 40 or more cannot fit any output width, so they pin to all-ones.
    always_comb begin
        mag    = 64'd0;
        guard  = 1'b0;
        sticky = 1'b0;
        nsh    = 10'(-sh1);
        ext    = 49'd0;
        if (!sh1[9]) begin
            if (sh1 >= 10'sd40) begin
                mag = {64{1'b1}};
            end else begin
                mag = {40'd0, m1} << sh1[5:0];
            end
        end else if (nsh >= 10'd25) begin
            sticky = 1'b1;
        end else begin
            ext    = {m1, 25'd0} >> nsh[4:0];
            mag    = {40'd0, ext[48:25]};
            guard  = ext[24];
            sticky = |ext[23:0];
        end
    end

`ifdef FP32_TO_INT_RNE_EN
    assign mag_r = mag + {63'd0, guard & (sticky | mag[0])};
`else
    assign mag_r = mag;
`endif

    // Saturate, negate and attach flags according to the operand class.
    always_comb begin
        res_data    = '0;
        res_ovf     = 1'b0;
        res_nan     = 1'b0;
        res_inexact = 1'b0;
        case (cls1)
            CLS_NAN: begin
                res_data = POS_SAT;
                res_nan  = 1'b1;
            end
            CLS_INF: begin
                res_data = s1 ? NEG_SAT : POS_SAT;
                res_ovf  = 1'b1;
            end
            CLS_DENORM: begin
                res_inexact = 1'b1;
            end
            CLS_NORMAL: begin
                res_inexact = guard | sticky;
                if (!s1 && (mag_r > POS_MAX)) begin
                    res_data = POS_SAT;
                    res_ovf  = 1'b1;
                end else if (s1 && (mag_r > NEG_MAX)) begin
                    res_data = NEG_SAT;
                    res_ovf  = 1'b1;
                end else begin
                    res_data = s1 ? -mag_r[OUT_W-1:0] : mag_r[OUT_W-1:0];
                end
            end
            default: begin
                res_data = '0;
            end
        endcase
    end

    // Stage 2 register: final word and flags, held while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2       <= 1'b0;
            data2    <= '0;
            ovf2     <= 1'b0;
            nan2     <= 1'b0;
            inexact2 <= 1'b0;
        end else if (adv1) begin
            v2 <= v1;
            if (v1) begin
                data2    <= res_data;
                ovf2     <= res_ovf;
                nan2     <= res_nan;
                inexact2 <= res_inexact;
            end
        end
    end

    assign bus.out_valid   = v2;
    assign bus.out_data    = data2;
    assign bus.out_ovf     = ovf2;
    assign bus.out_nan     = nan2;
    assign bus.out_inexact = inexact2;

endmodule

// File: tb/tb_fp32_to_int_conv.sv
// Testbench for fp32_to_int_conv. Two instances: the default 32-bit integer
// build and a 16-bit Q8 build. Expected results come from a real-arithmetic
// model of the conversion and are queued in acceptance order.
module tb_fp32_to_int_conv;

    typedef struct packed {
        logic [31:0] data;
        logic        ovf;
        logic        nan;
        logic        inexact;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp32_to_int_conv_if #(.OUT_W(32)) bus_a ();
    fp32_to_int_conv_if #(.OUT_W(16)) bus_b ();

    fp32_to_int_conv #(.OUT_W(32), .FRAC_BITS(0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    fp32_to_int_conv #(.OUT_W(16), .FRAC_BITS(8)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    int          n_checks = 0;
    int          n_fails  = 0;
    int          cyc      = 0;
    exp_t        exp_q[$];
    int          acc_q[$];
    logic        s_acc, s_pop, s_valid, s_ready;
    logic [31:0] s_data;
    logic        s_ovf, s_nan, s_inex;
    int          s_cyc;

    function automatic real pow2(input int k);
        real p;
        p = 1.0;
        if (k >= 0) repeat (k) p = p * 2.0;
        else        repeat (-k) p = p / 2.0;
        return p;
    endfunction

    // Value-level model: x * 2^f as an exact real, then round and clamp.
    function automatic exp_t ref_model(input logic [31:0] x, input int w, input int f);
        exp_t        r;
        real         a, t, fr, poslim, neglim;
        longint      v;
        logic [31:0] mask, pmax, nmin;
        r      = '0;
        mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        pmax   = (32'd1 << (w - 1)) - 32'd1;
        nmin   = 32'd1 << (w - 1);
        poslim = pow2(w - 1) - 1.0;
        neglim = pow2(w - 1);
        if (x[30:23] == 8'hFF && x[22:0] != 23'd0) begin
            r.data = pmax;
            r.nan  = 1'b1;
        end else if (x[30:23] == 8'hFF) begin
            r.data = x[31] ? nmin : pmax;
            r.ovf  = 1'b1;
        end else if (x[30:23] == 8'h00) begin
            r.inexact = (x[22:0] != 23'd0);
        end else begin
            a  = real'(int'({1'b1, x[22:0]})) * pow2(int'(x[30:23]) - 150 + f);
            t  = $floor(a);
            fr = a - t;
            r.inexact = (fr != 0.0);
`ifdef FP32_TO_INT_RNE_EN
            if (fr > 0.5 || (fr == 0.5 && (t - 2.0 * $floor(t / 2.0)) != 0.0)) t = t + 1.0;
`endif
            if (!x[31] && t > poslim) begin
                r.data = pmax;
                r.ovf  = 1'b1;
            end else if (x[31] && t > neglim) begin
                r.data = nmin;
                r.ovf  = 1'b1;
            end else begin
                v = longint'(t);
                if (x[31]) v = -v;
                r.data = 32'(v) & mask;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 9))
            0: x[30:23] = 8'hFF;
            1: x[30:23] = 8'h00;
            default: x[30:23] = 8'($urandom_range(100, 170));
        endcase
        return x;
    endfunction

    // Drive one cycle on instance A, sample mid-cycle, log accepts.
    task automatic step_a(input logic vin, input logic [31:0] din, input logic ordy);
        bus_a.in_valid  = vin;
        bus_a.in_data   = din;
        bus_a.out_ready = ordy;
        #3;
        s_ready = bus_a.in_ready;
        s_valid = bus_a.out_valid;
        s_data  = bus_a.out_data;
        s_ovf   = bus_a.out_ovf;
        s_nan   = bus_a.out_nan;
        s_inex  = bus_a.out_inexact;
        s_acc   = vin & s_ready;
        s_pop   = s_valid & ordy;
        s_cyc   = cyc;
        if (s_acc) begin
            exp_q.push_back(ref_model(din, 32, 0));
            acc_q.push_back(cyc);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Same as step_a for instance B (16-bit, 8 fractional bits).
    task automatic step_b(input logic vin, input logic [31:0] din, input logic ordy);
        bus_b.in_valid  = vin;
        bus_b.in_data   = din;
        bus_b.out_ready = ordy;
        #3;
        s_ready = bus_b.in_ready;
        s_valid = bus_b.out_valid;
        s_data  = {16'd0, bus_b.out_data};
        s_ovf   = bus_b.out_ovf;
        s_nan   = bus_b.out_nan;
        s_inex  = bus_b.out_inexact;
        s_acc   = vin & s_ready;
        s_pop   = s_valid & ordy;
        s_cyc   = cyc;
        if (s_acc) begin
            exp_q.push_back(ref_model(din, 16, 8));
            acc_q.push_back(cyc);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step_a(1'b0, 32'd0, 1'b1);
        n_checks++;
        if ({s_valid, s_data, s_ovf, s_nan, s_inex, s_ready} !== {1'b0, 32'd0, 3'b000, 1'b1}) begin
            n_fails++;
            $display("[TB] FAIL reset_a: got valid=%b data=%h flags=%b%b%b in_ready=%b, required 0 00000000 000 1",
                     s_valid, s_data, s_ovf, s_nan, s_inex, s_ready);
        end
        step_b(1'b0, 32'd0, 1'b1);
        n_checks++;
        if ({s_valid, s_data, s_ovf, s_nan, s_inex, s_ready} !== {1'b0, 32'd0, 3'b000, 1'b1}) begin
            n_fails++;
            $display("[TB] FAIL reset_b: got valid=%b data=%h flags=%b%b%b in_ready=%b, required 0 00000000 000 1",
                     s_valid, s_data, s_ovf, s_nan, s_inex, s_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] vec[13] = '{32'h3FC00000, 32'h40200000, 32'hC0400000, 32'h4F000000,
                                 32'hCF000000, 32'hFF800000, 32'h7F800000, 32'h7FC00000,
                                 32'h00000001, 32'h80000000, 32'h00000000, 32'h3F000000,
                                 32'hBF400000};
        exp_t        obs[13];
        exp_t        e;
        exp_t        want;
        int          npop;
        int          lat;
        npop = 0;
        for (int i = 0; i < 16; i++) begin
            if (i < 13) step_a(1'b1, vec[i], 1'b1);
            else        step_a(1'b0, 32'd0, 1'b1);
            if (s_pop) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fails++;
                    $display("[TB] FAIL directed_extra: got output %h, required none", s_data);
                end else begin
                    e   = exp_q.pop_front();
                    lat = s_cyc - acc_q.pop_front();
                    if ({s_data, s_ovf, s_nan, s_inex} !== e || lat != 2) begin
                        n_fails++;
                        $display("[TB] FAIL directed_%0d: got data=%h ovf=%b nan=%b inx=%b lat=%0d, required data=%h ovf=%b nan=%b inx=%b lat=2",
                                 npop, s_data, s_ovf, s_nan, s_inex, lat, e.data, e.ovf, e.nan, e.inexact);
                    end
                end
                if (npop < 13) obs[npop] = {s_data, s_ovf, s_nan, s_inex};
                npop++;
            end
        end
        n_checks++;
        if (npop != 13) begin
            n_fails++;
            $display("[TB] FAIL directed_count: got %0d outputs, required 13", npop);
        end
`ifdef FP32_TO_INT_RNE_EN
        want = {32'h00000002, 3'b001};
`else
        want = {32'h00000001, 3'b001};
`endif
        n_checks++;
        if (obs[0] !== want) begin
            n_fails++;
            $display("[TB] FAIL const_1p5: got %h, required %h", obs[0], want);
        end
        n_checks++;
        if (obs[2] !== {32'hFFFFFFFD, 3'b000}) begin
            n_fails++;
            $display("[TB] FAIL const_m3: got %h, required %h", obs[2], {32'hFFFFFFFD, 3'b000});
        end
        n_checks++;
        if ({obs[3], obs[4], obs[5]} !== {32'h7FFFFFFF, 3'b100, 32'h80000000, 3'b000, 32'h80000000, 3'b100}) begin
            n_fails++;
            $display("[TB] FAIL const_sat: got %h %h %h, required 7fffffff/ovf 80000000/none 80000000/ovf",
                     obs[3], obs[4], obs[5]);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] items[4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        logic [31:0] held;
        exp_t        e;
        int          idx;
        int          npop;
        int          first_pop;
        int          last_pop;
        idx  = 0;
        held = 32'd0;
        for (int k = 0; k < 6; k++) begin
            step_a(idx < 4, items[idx < 4 ? idx : 0], 1'b0);
            if (s_acc) idx++;
            if (k == 2) held = s_data;
            if (k > 2) begin
                n_checks++;
                if (s_valid !== 1'b1 || s_data !== held) begin
                    n_fails++;
                    $display("[TB] FAIL bp_hold: got valid=%b data=%h, required 1 %h", s_valid, s_data, held);
                end
            end
        end
        n_checks++;
        if (idx != 2 || s_ready !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL bp_accepts: got %0d accepts in_ready=%b, required 2 accepts in_ready=0", idx, s_ready);
        end
        npop      = 0;
        first_pop = -1;
        last_pop  = -1;
        for (int k = 0; k < 8; k++) begin
            step_a(idx < 4, items[idx < 4 ? idx : 0], 1'b1);
            if (s_acc) idx++;
            if (s_pop) begin
                if (first_pop < 0) first_pop = s_cyc;
                last_pop = s_cyc;
                npop++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fails++;
                    $display("[TB] FAIL bp_extra: got output %h, required none", s_data);
                end else begin
                    e = exp_q.pop_front();
                    void'(acc_q.pop_front());
                    if ({s_data, s_ovf, s_nan, s_inex} !== e) begin
                        n_fails++;
                        $display("[TB] FAIL bp_data_%0d: got %h, required %h", npop,
                                 {s_data, s_ovf, s_nan, s_inex}, e);
                    end
                end
            end
        end
        n_checks++;
        if (npop != 4 || last_pop - first_pop != 3) begin
            n_fails++;
            $display("[TB] FAIL bp_drain: got %0d outputs over %0d cycles, required 4 over 3",
                     npop, last_pop - first_pop);
        end
    endtask

    task automatic test_random();
        exp_t        e;
        logic        ordy;
        logic        prev_stall;
        logic [34:0] prev_out;
        prev_stall = 1'b0;
        prev_out   = '0;
        for (int k = 0; k < 420; k++) begin
            ordy = (k >= 400) ? 1'b1 : ($urandom_range(0, 3) != 0);
            step_a((k < 400) && ($urandom_range(0, 3) != 0), rand_fp(), ordy);
            if (prev_stall) begin
                n_checks++;
                if (s_valid !== 1'b1 || {s_data, s_ovf, s_nan, s_inex} !== prev_out) begin
                    n_fails++;
                    $display("[TB] FAIL rand_hold: got valid=%b out=%h, required 1 %h",
                             s_valid, {s_data, s_ovf, s_nan, s_inex}, prev_out);
                end
            end
            prev_stall = s_valid & !ordy;
            prev_out   = {s_data, s_ovf, s_nan, s_inex};
            if (s_pop) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fails++;
                    $display("[TB] FAIL rand_extra: got output %h, required none", s_data);
                end else begin
                    e = exp_q.pop_front();
                    void'(acc_q.pop_front());
                    if ({s_data, s_ovf, s_nan, s_inex} !== e) begin
                        n_fails++;
                        $display("[TB] FAIL rand_data: got %h, required %h",
                                 {s_data, s_ovf, s_nan, s_inex}, e);
                    end
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("[TB] FAIL rand_drain: got %0d items left, required 0", exp_q.size());
        end
        exp_q.delete();
        acc_q.delete();
    endtask

    task automatic test_reset_midstream();
        step_a(1'b1, 32'h40A00000, 1'b0);
        step_a(1'b1, 32'h40C00000, 1'b0);
        rst = 1'b1;
        step_a(1'b0, 32'd0, 1'b0);
        rst = 1'b0;
        exp_q.delete();
        acc_q.delete();
        step_a(1'b0, 32'd0, 1'b1);
        n_checks++;
        if ({s_valid, s_data, s_ovf, s_nan, s_inex, s_ready} !== {1'b0, 32'd0, 3'b000, 1'b1}) begin
            n_fails++;
            $display("[TB] FAIL midreset: got valid=%b data=%h flags=%b%b%b in_ready=%b, required 0 00000000 000 1",
                     s_valid, s_data, s_ovf, s_nan, s_inex, s_ready);
        end
        for (int k = 0; k < 4; k++) begin
            step_a(1'b0, 32'd0, 1'b1);
            n_checks++;
            if (s_valid !== 1'b0) begin
                n_fails++;
                $display("[TB] FAIL midreset_stale: got out_valid=%b data=%h, required 0", s_valid, s_data);
            end
        end
    endtask

    task automatic test_frac_bits();
        logic [31:0] vec[5] = '{32'h3FC00000, 32'h47000000, 32'hC7000000, 32'h3B800000, 32'h3B000000};
        exp_t        e;
        int          npop;
        npop = 0;
        for (int i = 0; i < 48; i++) begin
            if (i < 5)       step_b(1'b1, vec[i], 1'b1);
            else if (i < 45) step_b(1'b1, {rand_fp()} & 32'hC7FFFFFF | 32'h04000000, 1'b1);
            else             step_b(1'b0, 32'd0, 1'b1);
            if (s_pop) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fails++;
                    $display("[TB] FAIL q8_extra: got output %h, required none", s_data);
                end else begin
                    e = exp_q.pop_front();
                    void'(acc_q.pop_front());
                    if ({s_data, s_ovf, s_nan, s_inex} !== e) begin
                        n_fails++;
                        $display("[TB] FAIL q8_data_%0d: got %h, required %h", npop,
                                 {s_data, s_ovf, s_nan, s_inex}, e);
                    end
                end
                if (npop == 0) begin
                    n_checks++;
                    if ({s_data, s_ovf} !== {32'h00000180, 1'b0}) begin
                        n_fails++;
                        $display("[TB] FAIL q8_1p5: got %h ovf=%b, required 00000180 ovf=0", s_data, s_ovf);
                    end
                end
                if (npop == 1) begin
                    n_checks++;
                    if ({s_data, s_ovf} !== {32'h00007FFF, 1'b1}) begin
                        n_fails++;
                        $display("[TB] FAIL q8_sat: got %h ovf=%b, required 00007fff ovf=1", s_data, s_ovf);
                    end
                end
                npop++;
            end
        end
        n_checks++;
        if (npop != 45) begin
            n_fails++;
            $display("[TB] FAIL q8_count: got %0d outputs, required 45", npop);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        bus_a.in_valid  = 1'b0;
        bus_a.in_data   = 32'd0;
        bus_a.out_ready = 1'b1;
        bus_b.in_valid  = 1'b0;
        bus_b.in_data   = 32'd0;
        bus_b.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        $display("[TB] starting");
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_midstream();
        bus_a.in_valid = 1'b0;
        test_frac_bits();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
